// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
//
// Sequences the dynamic-loop-filter PLL wrapper: it holds the PLL in reset,
// waits for a stable lock, and then turns on the three output clock enables
// one after another before it reports ready. A failed acquisition is retried
// with a stronger charge pump and a larger loop-filter resistor. When every
// attempt has failed, a sticky fail flag is raised.
//
// Ports
//   clkin          in   PLL reference clock; all logic runs on its rising edge
//   reset          in   asynchronous, active-high
//   pll_lock       in   PLL lock output (asynchronous, synchronized here)
//   restart        in   single-cycle request to re-acquire from attempt 0
//   pll_reset      out  PLL reset
//   icpsel[5:0]    out  charge-pump current select
//   lpfres[2:0]    out  loop-filter resistor select
//   lpfcap[1:0]    out  loop-filter capacitor select (constant)
//   enclk0..2      out  per-output clock enables
//   ready          out  locked and all enables on
//   fail           out  sticky; all attempts exhausted
//   attempt[1:0]   out  current attempt index
//   lock_loss_cnt  out  saturating count of lock losses after lock was declared
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT = 500000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned EN_GAP       = 16,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [5:0]  ICP_BASE     = 6'd16,
  parameter logic [5:0]  ICP_STEP     = 6'd8,
  parameter logic [2:0]  LPF_RES_BASE = 3'd2,
  parameter logic [1:0]  LPF_CAP      = 2'b00
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic [5:0] icpsel,
  output logic [2:0] lpfres,
  output logic [1:0] lpfcap,
  output logic       enclk0,
  output logic       enclk1,
  output logic       enclk2,
  output logic       ready,
  output logic       fail,
  output logic [1:0] attempt,
  output logic [7:0] lock_loss_cnt
);

  localparam int RST_W = $clog2(RST_CYCLES) + 1;
  localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int ST_W  = $clog2(LOCK_STABLE) + 1;
  localparam int EN_W  = $clog2(3 * EN_GAP) + 1;

  typedef enum logic [2:0] {
    ST_RST,
    ST_WAIT,
    ST_STABLE,
    ST_EN,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t           state_reg, state_next;
  logic [RST_W-1:0] rst_cnt_reg, rst_cnt_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic [ST_W-1:0]  stab_cnt_reg, stab_cnt_next;
  logic [EN_W-1:0]  en_cnt_reg, en_cnt_next;

  logic       lock_meta_reg, lock_s_reg;
  logic       pll_reset_reg, pll_reset_next;
  logic [5:0] icpsel_reg, icpsel_next;
  logic [2:0] lpfres_reg, lpfres_next;
  logic [1:0] lpfcap_reg;
  logic [2:0] en_reg, en_next;
  logic       ready_reg, ready_next;
  logic       fail_reg, fail_next;
  logic [1:0] attempt_reg, attempt_next;
  logic [7:0] loss_cnt_reg, loss_cnt_next;

  logic go_rst;
  logic lock_loss;

  // Loop settings for a given attempt. The sum is formed wide enough that it
  // cannot wrap, and the result is then clamped to the field maximum.
  function automatic logic [5:0] icp_for(input logic [1:0] a);
    logic [8:0] sum;
    sum = {3'b000, ICP_BASE} + 9'(a) * {3'b000, ICP_STEP};
    return (sum > 9'd63) ? 6'd63 : sum[5:0];
  endfunction

  function automatic logic [2:0] lpf_for(input logic [1:0] a);
    logic [3:0] sum;
    sum = {1'b0, LPF_RES_BASE} + {2'b00, a};
    return (sum > 4'd7) ? 3'd7 : sum[2:0];
  endfunction

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
      state_reg     <= ST_RST;
      rst_cnt_reg   <= '0;
      to_cnt_reg    <= '0;
      stab_cnt_reg  <= '0;
      en_cnt_reg    <= '0;
      pll_reset_reg <= 1'b1;
      icpsel_reg    <= ICP_BASE;
      lpfres_reg    <= LPF_RES_BASE;
      lpfcap_reg    <= LPF_CAP;
      en_reg        <= '0;
      ready_reg     <= 1'b0;
      fail_reg      <= 1'b0;
      attempt_reg   <= '0;
      loss_cnt_reg  <= '0;
    end else begin
      lock_meta_reg <= pll_lock;
      lock_s_reg    <= lock_meta_reg;
      state_reg     <= state_next;
      rst_cnt_reg   <= rst_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      stab_cnt_reg  <= stab_cnt_next;
      en_cnt_reg    <= en_cnt_next;
      pll_reset_reg <= pll_reset_next;
      icpsel_reg    <= icpsel_next;
      lpfres_reg    <= lpfres_next;
      lpfcap_reg    <= LPF_CAP;
      en_reg        <= en_next;
      ready_reg     <= ready_next;
      fail_reg      <= fail_next;
      attempt_reg   <= attempt_next;
      loss_cnt_reg  <= loss_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rst_cnt_next   = rst_cnt_reg;
    to_cnt_next    = to_cnt_reg;
    stab_cnt_next  = stab_cnt_reg;
    en_cnt_next    = en_cnt_reg;
    pll_reset_next = pll_reset_reg;
    icpsel_next    = icpsel_reg;
    lpfres_next    = lpfres_reg;
    en_next        = en_reg;
    ready_next     = ready_reg;
    fail_next      = fail_reg;
    attempt_next   = attempt_reg;
    loss_cnt_next  = loss_cnt_reg;
    go_rst         = 1'b0;
    lock_loss      = 1'b0;

    case (state_reg)
      ST_RST: begin
        if (rst_cnt_reg >= RST_W'(RST_CYCLES - 1)) begin
          pll_reset_next = 1'b0;
          to_cnt_next    = '0;
          state_next     = ST_WAIT;
        end else begin
          rst_cnt_next = rst_cnt_reg + RST_W'(1);
        end
      end

      // WAIT and STABLE share one timeout budget that is measured from the
      // pll_reset release. A lock drop in STABLE therefore does not extend it.
      ST_WAIT, ST_STABLE: begin
        if (to_cnt_reg >= TO_W'(LOCK_TIMEOUT - 1)) begin
          if ((32'(attempt_reg) + 32'd1) >= MAX_RETRY) begin
            fail_next      = 1'b1;
            pll_reset_next = 1'b1;
            state_next     = ST_FAIL;
          end else begin
            attempt_next = attempt_reg + 2'd1;
            go_rst       = 1'b1;
          end
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
          if (state_reg == ST_WAIT) begin
            if (lock_s_reg) begin
              stab_cnt_next = ST_W'(1);
              state_next    = ST_STABLE;
            end
          end else if (!lock_s_reg) begin
            state_next = ST_WAIT;
          end else if (stab_cnt_reg >= ST_W'(LOCK_STABLE - 1)) begin
            // This cycle supplies the final lock-high sample that is needed.
            en_next     = 3'b001;
            en_cnt_next = '0;
            state_next  = ST_EN;
          end else begin
            stab_cnt_next = stab_cnt_reg + ST_W'(1);
          end
        end
      end

      ST_EN: begin
        if (!lock_s_reg) begin
          lock_loss = 1'b1;
        end else begin
          en_cnt_next = en_cnt_reg + EN_W'(1);
          if (en_cnt_reg == EN_W'(EN_GAP - 1))     en_next[1] = 1'b1;
          if (en_cnt_reg == EN_W'(2 * EN_GAP - 1)) en_next[2] = 1'b1;
          if (en_cnt_reg == EN_W'(3 * EN_GAP - 1)) begin
            ready_next = 1'b1;
            state_next = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (!lock_s_reg) lock_loss = 1'b1;
      end

      ST_FAIL: begin
        // Only restart or reset can leave this state.
      end

      default: go_rst = 1'b1;
    endcase

    if (lock_loss) begin
      if (loss_cnt_reg != 8'hFF) loss_cnt_next = loss_cnt_reg + 8'd1;
      attempt_next = '0;
      go_rst       = 1'b1;
    end

    // Restart is evaluated last, so it overrides a timeout or lock loss in the
    // same cycle. The lock-loss count is left untouched.
    if (restart) begin
      loss_cnt_next = loss_cnt_reg;
      attempt_next  = '0;
      fail_next     = 1'b0;
      go_rst        = 1'b1;
    end

    // Loop settings change only on entry to RST. At that point pll_reset is
    // high, so the PLL never sees its settings move while it runs.
    if (go_rst) begin
      state_next     = ST_RST;
      rst_cnt_next   = '0;
      pll_reset_next = 1'b1;
      en_next        = '0;
      ready_next     = 1'b0;
      icpsel_next    = icp_for(attempt_next);
      lpfres_next    = lpf_for(attempt_next);
    end
  end

  assign pll_reset     = pll_reset_reg;
  assign icpsel        = icpsel_reg;
  assign lpfres        = lpfres_reg;
  assign lpfcap        = lpfcap_reg;
  assign enclk0        = en_reg[0];
  assign enclk1        = en_reg[1];
  assign enclk2        = en_reg[2];
  assign ready         = ready_reg;
  assign fail          = fail_reg;
  assign attempt       = attempt_reg;
  assign lock_loss_cnt = loss_cnt_reg;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Testbench for pll_lock_ctrl, built with short timing parameters.
module tb_pll_lock_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 100;
  localparam int LOCK_STABLE  = 8;
  localparam int EN_GAP       = 2;
  localparam int MAX_RETRY    = 3;

  logic       clkin    = 1'b0;
  logic       reset    = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart  = 1'b0;
  logic       pll_reset;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap;
  logic       enclk0, enclk1, enclk2;
  logic       ready, fail;
  logic [1:0] attempt;
  logic [7:0] lock_loss_cnt;

  always #5 clkin = ~clkin;

  pll_lock_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .EN_GAP      (EN_GAP),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .restart      (restart),
    .pll_reset    (pll_reset),
    .icpsel       (icpsel),
    .lpfres       (lpfres),
    .lpfcap       (lpfcap),
    .enclk0       (enclk0),
    .enclk1       (enclk1),
    .enclk2       (enclk2),
    .ready        (ready),
    .fail         (fail),
    .attempt      (attempt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0d", tag, got);
    end
  endtask

  task automatic expect_val(input int v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    int e;
    if (exp_q.size() == 0) e = -999;
    else e = exp_q.pop_front();
    check(tag, got, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return pll_reset;
      1: return enclk0;
      2: return enclk1;
      3: return enclk2;
      4: return ready;
      default: return fail;
    endcase
  endfunction

  // Counts negedges until the selected output equals val. If the limit expires, it returns -1.
  task automatic wait_sig(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (sig(sel) !== val && n < limit) begin
      step(1);
      n++;
    end
    if (sig(sel) !== val) n = -1;
  endtask

  task automatic check_reset_state(input string pfx);
    expect_val(1);  sb_check({pfx, "_pll_reset"}, pll_reset);
    expect_val(16); sb_check({pfx, "_icpsel"}, icpsel);
    expect_val(2);  sb_check({pfx, "_lpfres"}, lpfres);
    expect_val(0);  sb_check({pfx, "_lpfcap"}, lpfcap);
    expect_val(0);  sb_check({pfx, "_enables"}, {enclk2, enclk1, enclk0});
    expect_val(0);  sb_check({pfx, "_ready"}, ready);
    expect_val(0);  sb_check({pfx, "_fail"}, fail);
    expect_val(0);  sb_check({pfx, "_attempt"}, attempt);
    expect_val(0);  sb_check({pfx, "_lock_loss_cnt"}, lock_loss_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int chg;
    int en_seen;
    logic [5:0] icp0;
    logic [2:0] lpf0;

    // Power-on reset, followed by the best-case acquisition.
    reset = 1'b1;
    step(3);
    check_reset_state("por");
    reset = 1'b0;
    expect_val(RST_CYCLES); wait_sig(0, 1'b0, 20, n); sb_check("t1_rst_len", n);
    pll_lock = 1'b1;
    expect_val(2 + LOCK_STABLE); wait_sig(1, 1'b1, 50, n); sb_check("t1_enclk0_delay", n);
    expect_val(EN_GAP); wait_sig(2, 1'b1, 20, n); sb_check("t1_enclk1_gap", n);
    expect_val(EN_GAP); wait_sig(3, 1'b1, 20, n); sb_check("t1_enclk2_gap", n);
    expect_val(EN_GAP); wait_sig(4, 1'b1, 20, n); sb_check("t1_ready_gap", n);
    expect_val(16); sb_check("t1_icpsel", icpsel);
    expect_val(2);  sb_check("t1_lpfres", lpfres);
    expect_val(7);  sb_check("t1_enables_all", {enclk2, enclk1, enclk0});

    // One-cycle lock drop in RUN.
    step(3);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    wait_sig(4, 1'b0, 10, n);
    expect_val(3); sb_check("t4_drop_latency", (n < 0) ? n : n + 1);
    expect_val(0); sb_check("t4_enables_off", {enclk2, enclk1, enclk0});
    expect_val(1); sb_check("t4_pll_reset", pll_reset);
    expect_val(1); sb_check("t4_lock_loss_cnt", lock_loss_cnt);
    expect_val(0); sb_check("t4_attempt", attempt);
    expect_val(RST_CYCLES); wait_sig(0, 1'b0, 20, n); sb_check("t4_rst_len", n);
    expect_val(16); sb_check("t4_icpsel", icpsel);
    expect_val(LOCK_STABLE + 3 * EN_GAP); wait_sig(4, 1'b1, 50, n); sb_check("t4_reacquire", n);

    // Restart and a lock loss that land on the same edge.
    step(2);
    pll_lock = 1'b0;
    step(2);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    pll_lock = 1'b1;
    expect_val(1); sb_check("t5_lock_loss_cnt", lock_loss_cnt);
    expect_val(1); sb_check("t5_pll_reset", pll_reset);
    expect_val(0); sb_check("t5_ready", ready);
    expect_val(RST_CYCLES); wait_sig(0, 1'b0, 20, n); sb_check("t5_rst_len", n);
    expect_val(0); sb_check("t5_attempt", attempt);

    // Asynchronous reset asserted in the middle of EN.
    expect_val(LOCK_STABLE); wait_sig(1, 1'b1, 50, n); sb_check("t6_enclk0_delay", n);
    step(1);
    #2 reset = 1'b1;
    #1 check_reset_state("async");
    step(2);
    pll_lock = 1'b0;
    step(1);
    reset = 1'b0;

    // No lock: three attempts, then fail.
    for (int k = 0; k < MAX_RETRY; k++) begin
      expect_val(16 + 8 * k); sb_check($sformatf("t2_icpsel_a%0d", k), icpsel);
      expect_val(2 + k);      sb_check($sformatf("t2_lpfres_a%0d", k), lpfres);
      expect_val(k);          sb_check($sformatf("t2_attempt_a%0d", k), attempt);
      expect_val(RST_CYCLES); wait_sig(0, 1'b0, 20, n); sb_check($sformatf("t2_rst_len_a%0d", k), n);
      chg = 0;
      n = 0;
      icp0 = icpsel;
      lpf0 = lpfres;
      while (pll_reset === 1'b0 && n < 200) begin
        step(1);
        n++;
        if (pll_reset === 1'b0 && (icpsel !== icp0 || lpfres !== lpf0)) chg++;
      end
      expect_val(LOCK_TIMEOUT); sb_check($sformatf("t2_timeout_a%0d", k), n);
      expect_val(0); sb_check($sformatf("t2_settings_moved_a%0d", k), chg);
    end
    expect_val(1); sb_check("t2_fail", fail);
    expect_val(1); sb_check("t2_fail_pll_reset", pll_reset);
    step(10);
    expect_val(1); sb_check("t2_fail_sticky", fail);
    expect_val(2); sb_check("t2_fail_attempt", attempt);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    expect_val(0);  sb_check("t2_restart_fail", fail);
    expect_val(0);  sb_check("t2_restart_attempt", attempt);
    expect_val(16); sb_check("t2_restart_icpsel", icpsel);
    expect_val(1);  sb_check("t2_restart_pll_reset", pll_reset);

    // Lock drops low every fifth cycle, so it never stays up long enough.
    expect_val(RST_CYCLES); wait_sig(0, 1'b0, 20, n); sb_check("t3_rst_len", n);
    n = 0;
    en_seen = 0;
    while (pll_reset === 1'b0 && n < 200) begin
      pll_lock = (n % 5 != 4);
      step(1);
      n++;
      if (enclk0 === 1'b1) en_seen = 1;
    end
    pll_lock = 1'b0;
    expect_val(LOCK_TIMEOUT); sb_check("t3_timeout", n);
    expect_val(0);  sb_check("t3_en_entered", en_seen);
    expect_val(1);  sb_check("t3_attempt", attempt);
    expect_val(24); sb_check("t3_icpsel", icpsel);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
